// File: rtl/dxt_diff_pkg.sv
// Shared constants and types for the dxT (adjoint horizontal difference) engine.
// Frame geometry, fp16 word layout and the fixed subtractor latency live here so
// the address counters, the datapath and the bench agree on one set of numbers.
package dxt_diff_pkg;

   localparam int PORT_SIZE = 16;
   localparam int COL_WIDTH = 4;
   localparam int ROW_NUM   = 48;
   localparam int FP16_W    = 16;
   localparam int SUB_LAT   = 3;

   localparam int ROW_W     = PORT_SIZE * COL_WIDTH;
   localparam int N_WORDS   = ROW_NUM * COL_WIDTH;
   localparam int WORD_W    = PORT_SIZE * FP16_W;
   localparam int ADDR_W    = 8;
   localparam int COL_BITS  = $clog2(COL_WIDTH);
   localparam int ROW_BITS  = $clog2(ROW_NUM);

   typedef logic [FP16_W-1:0] fp16_t;

   localparam fp16_t FP16_ZERO = 16'h0000;

endpackage

// File: rtl/dxt_addr_counter.sv
// Row/column word-address counter for the dxT frame walk.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (advance),
// col (current column), addr (row*COL_WIDTH+col), last (at final word).
// Column ascends first, then row; wraps to 0 after the final word.
module dxt_addr_counter
   import dxt_diff_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   output logic [COL_BITS-1:0] col,
   output logic [ADDR_W-1:0]   addr,
   output logic                last
);

   logic [ROW_BITS-1:0] row;

   assign last = (col == COL_BITS'(COL_WIDTH - 1)) && (row == ROW_BITS'(ROW_NUM - 1));
   assign addr = ADDR_W'(row) * ADDR_W'(COL_WIDTH) + ADDR_W'(col);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (last) begin
            col <= '0;
            row <= '0;
         end else if (col == COL_BITS'(COL_WIDTH - 1)) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp16_subtract.sv
// fp16 subtractor core, y = a - b, round-to-nearest-even, 3-cycle latency.
// Ports: clk, rst (sync, active-high), a/b operands, y registered result.
// Operands are expanded to an exact 40-bit fixed-point magnitude (LSB = 2^-24),
// so the add/subtract is exact and only the final normalisation rounds.
// An exact zero difference of opposite-signed operands gives +0.
module fp16_subtract (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   localparam logic [15:0] QNAN = 16'h7E00;

   // stage 1: decode and align into fixed point
   logic [4:0]  ea, eb;
   logic [10:0] sig_a, sig_b;
   logic [39:0] fix_a, fix_b;
   logic        nan_a, nan_b, inf_a, inf_b, sb_eff, spec;
   logic [15:0] spec_y;

   always_comb begin
      ea     = a[14:10];
      eb     = b[14:10];
      sig_a  = {ea != 5'd0, a[9:0]};
      sig_b  = {eb != 5'd0, b[9:0]};
      fix_a  = 40'(sig_a) << ((ea == 5'd0) ? 5'd0 : ea - 5'd1);
      fix_b  = 40'(sig_b) << ((eb == 5'd0) ? 5'd0 : eb - 5'd1);
      sb_eff = ~b[15];
      nan_a  = (ea == 5'd31) && (a[9:0] != 10'd0);
      nan_b  = (eb == 5'd31) && (b[9:0] != 10'd0);
      inf_a  = (ea == 5'd31) && (a[9:0] == 10'd0);
      inf_b  = (eb == 5'd31) && (b[9:0] == 10'd0);
      spec   = 1'b0;
      spec_y = QNAN;
      if (nan_a || nan_b || (inf_a && inf_b && (a[15] != sb_eff))) begin
         spec   = 1'b1;
         spec_y = QNAN;
      end else if (inf_a) begin
         spec   = 1'b1;
         spec_y = a;
      end else if (inf_b) begin
         spec   = 1'b1;
         spec_y = {sb_eff, 15'h7C00};
      end
   end

   logic [39:0] s1_fa, s1_fb;
   logic        s1_sa, s1_sb, s1_spec;
   logic [15:0] s1_spec_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_fa     <= '0;
         s1_fb     <= '0;
         s1_sa     <= 1'b0;
         s1_sb     <= 1'b0;
         s1_spec   <= 1'b0;
         s1_spec_y <= '0;
      end else begin
         s1_fa     <= fix_a;
         s1_fb     <= fix_b;
         s1_sa     <= a[15];
         s1_sb     <= sb_eff;
         s1_spec   <= spec;
         s1_spec_y <= spec_y;
      end
   end

   // stage 2: exact signed-magnitude add
   logic [40:0] mag;
   logic        sgn;

   always_comb begin
      if (s1_sa == s1_sb) begin
         mag = {1'b0, s1_fa} + {1'b0, s1_fb};
         sgn = s1_sa;
      end else if (s1_fa >= s1_fb) begin
         mag = {1'b0, s1_fa - s1_fb};
         sgn = (s1_fa == s1_fb) ? 1'b0 : s1_sa;
      end else begin
         mag = {1'b0, s1_fb - s1_fa};
         sgn = s1_sb;
      end
   end

   logic [40:0] s2_mag;
   logic        s2_sgn, s2_spec;
   logic [15:0] s2_spec_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_mag    <= '0;
         s2_sgn    <= 1'b0;
         s2_spec   <= 1'b0;
         s2_spec_y <= '0;
      end else begin
         s2_mag    <= mag;
         s2_sgn    <= sgn;
         s2_spec   <= s1_spec;
         s2_spec_y <= s1_spec_y;
      end
   end

   // stage 3: normalise and round; mantissa carry ripples into the exponent field
   logic [5:0]  lead, shift, exp_u;
   logic [9:0]  sig;
   logic [40:0] rem, half;
   logic        rnd;
   logic [15:0] res;

   always_comb begin
      lead = '0;
      for (int i = 0; i < 41; i++) begin
         if (s2_mag[i]) lead = 6'(i);
      end
      shift = lead - 6'd10;
      exp_u = lead - 6'd9;
      sig   = 10'(s2_mag >> shift);
      rem   = s2_mag & ((41'd1 << shift) - 41'd1);
      half  = (shift == 6'd0) ? '0 : (41'd1 << (shift - 6'd1));
      rnd   = (shift != 6'd0) && ((rem > half) || ((rem == half) && sig[0]));
      res   = {s2_sgn, 15'd0};
      if (s2_mag == '0) begin
         res = {s2_sgn, 15'd0};
      end else if (lead < 6'd10) begin
         res = {s2_sgn, 5'd0, s2_mag[9:0]};
      end else if (exp_u >= 6'd31) begin
         res = {s2_sgn, 15'h7C00};
      end else begin
         res = {s2_sgn, {exp_u[4:0], sig} + 15'(rnd)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) y <= '0;
      else     y <= s2_spec ? s2_spec_y : res;
   end

endmodule

// File: rtl/dxt_diff.sv
// dxT engine: adjoint of the horizontal forward difference, one frame per start.
// Ports: clk, rst (sync, active-high), start (pulse), busy, done (pulse),
// ren/raddr/din source BRAM read port (din one cycle after ren),
// wen/waddr/dout destination BRAM write port.
// Per row: dxt[0] = -d[0], dxt[p] = d[p-1] - d[p], dxt[W-1] = d[W-2].
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start
// ST_READ  | issuing one source read per cycle, words 0..N-1
// ST_DRAIN | reads finished, waiting for the last write
// ST_DONE  | one-cycle done pulse
module dxt_diff
   import dxt_diff_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ren,
   output logic [ADDR_W-1:0] raddr,
   input  logic [WORD_W-1:0] din,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [WORD_W-1:0] dout
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]          state;
   logic                start_acc;
   logic [COL_BITS-1:0] rd_col, unused_wr_col;
   logic                rd_last, wr_last;
   logic                rvalid;
   logic [COL_BITS-1:0] rcol;
   fp16_t               carry;
   logic [SUB_LAT-1:0]  vpipe;
   fp16_t               minu [PORT_SIZE];
   fp16_t               subt [PORT_SIZE];

   assign start_acc = (state == ST_IDLE) && start;
   assign ren       = (state == ST_READ);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign wen       = vpipe[SUB_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state <= ST_READ;
            ST_READ:  if (rd_last) state <= ST_DRAIN;
            ST_DRAIN: if (wen && wr_last) state <= ST_DONE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   dxt_addr_counter u_rd_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_acc),
      .en   (ren),
      .col  (rd_col),
      .addr (raddr),
      .last (rd_last)
   );

   dxt_addr_counter u_wr_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_acc),
      .en   (wen),
      .col  (unused_wr_col),
      .addr (waddr),
      .last (wr_last)
   );

   // carry holds the previous word's top lane; it is only meaningful within a row
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rcol   <= '0;
         carry  <= FP16_ZERO;
         vpipe  <= '0;
      end else begin
         rvalid <= ren;
         rcol   <= rd_col;
         if (rvalid) carry <= din[(PORT_SIZE-1)*FP16_W +: FP16_W];
         vpipe  <= {vpipe[SUB_LAT-2:0], rvalid};
      end
   end

   always_comb begin
      minu[0] = (rcol == '0) ? FP16_ZERO : carry;
      subt[0] = din[0 +: FP16_W];
      for (int l = 1; l < PORT_SIZE; l++) begin
         minu[l] = din[(l-1)*FP16_W +: FP16_W];
         subt[l] = din[l*FP16_W +: FP16_W];
      end
      // right image edge: the pixel beyond the row is treated as zero
      if (rcol == COL_BITS'(COL_WIDTH - 1)) subt[PORT_SIZE-1] = FP16_ZERO;
   end

   for (genvar l = 0; l < PORT_SIZE; l++) begin : g_lane
      fp16_subtract u_sub (
         .clk (clk),
         .rst (rst),
         .a   (minu[l]),
         .b   (subt[l]),
         .y   (dout[l*FP16_W +: FP16_W])
      );
   end

endmodule

// File: tb/tb_dxt_diff.sv
module tb_dxt_diff;
   import dxt_diff_pkg::*;

   logic              clk = 1'b0;
   logic              rst, start;
   logic              busy, done, ren, wen;
   logic [ADDR_W-1:0] raddr, waddr;
   logic [WORD_W-1:0] din, dout;

   always #5 clk = ~clk;

   dxt_diff dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .ren   (ren),
      .raddr (raddr),
      .din   (din),
      .wen   (wen),
      .waddr (waddr),
      .dout  (dout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference fp16 arithmetic via exact real values
   function automatic real p2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp_to_real(input logic [15:0] h);
      int  e = int'(h[14:10]);
      int  m = int'(h[9:0]);
      real v;
      v = (e == 0) ? real'(m) * p2(-24) : real'(1024 + m) * p2(e - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic int rne(input real q);
      real fl = $floor(q);
      real fr = q - fl;
      int  n  = int'(fl);
      if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
      return n;
   endfunction

   function automatic logic [15:0] real_to_fp(input real r);
      logic sgn = (r < 0.0);
      real  m   = sgn ? -r : r;
      int   e, n;
      if (m >= 65520.0) return {sgn, 15'h7C00};
      if (m < p2(-14)) begin
         n = rne(m * p2(24));
         return {sgn, 15'(n)};
      end
      e = -14;
      while (m >= p2(e + 1)) e++;
      n = rne(m * p2(10 - e));
      return {sgn, 15'((e + 15) * 1024 + n - 1024)};
   endfunction

   function automatic logic [15:0] fp_sub_ref(input logic [15:0] a, input logic [15:0] b);
      real r = fp_to_real(a) - fp_to_real(b);
      if (r == 0.0) return (a == 16'h8000 && b == 16'h0000) ? 16'h8000 : 16'h0000;
      return real_to_fp(r);
   endfunction

   logic [WORD_W-1:0] src_mem [N_WORDS];
   logic [WORD_W-1:0] exp_mem [N_WORDS];
   logic [WORD_W-1:0] dst_mem [N_WORDS];

   function automatic logic [15:0] src_pix(input int r, input int p);
      return src_mem[r*COL_WIDTH + p/PORT_SIZE][(p%PORT_SIZE)*FP16_W +: FP16_W];
   endfunction

   task automatic build_expected();
      logic [15:0] prv, cur;
      for (int r = 0; r < ROW_NUM; r++)
         for (int p = 0; p < ROW_W; p++) begin
            prv = (p == 0)       ? 16'h0000 : src_pix(r, p - 1);
            cur = (p == ROW_W-1) ? 16'h0000 : src_pix(r, p);
            exp_mem[r*COL_WIDTH + p/PORT_SIZE][(p%PORT_SIZE)*FP16_W +: FP16_W] = fp_sub_ref(prv, cur);
         end
   endtask

   function automatic logic [15:0] rnd_fp16();
      int k = int'($urandom_range(0, 19));
      if (k == 0) return 16'h0000;
      if (k == 1) return 16'h8000;
      return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 29)), 10'($urandom_range(0, 1023))};
   endfunction

   task automatic gen_frame(input bit ramp_row0);
      logic [15:0] v, prv;
      prv = 16'h0000;
      for (int r = 0; r < ROW_NUM; r++)
         for (int p = 0; p < ROW_W; p++) begin
            v = rnd_fp16();
            if (p > 0 && $urandom_range(0, 7) == 0) v = prv;
            if (ramp_row0 && r == 0) v = real_to_fp(real'(p));
            src_mem[r*COL_WIDTH + p/PORT_SIZE][(p%PORT_SIZE)*FP16_W +: FP16_W] = v;
            prv = v;
         end
      build_expected();
   endtask

   // source BRAM: word appears on din one cycle after ren
   logic              ren_s = 1'b0;
   logic [ADDR_W-1:0] raddr_s = '0;
   always @(negedge clk) begin
      ren_s   = ren;
      raddr_s = raddr;
   end
   always @(posedge clk) begin
      #1;
      if (ren_s) din = src_mem[raddr_s];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int acc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   int first_ren_k = -1, first_wen_k = -1, done_k = -1;

   always @(negedge clk) begin
      if (ren) begin
         check("raddr", raddr, rd_cnt);
         if (first_ren_k < 0) first_ren_k = cyc - acc;
         rd_cnt++;
      end
      if (wen) begin
         check("waddr", waddr, wr_cnt);
         if (wr_cnt < N_WORDS) begin
            check($sformatf("dout[%0d]", wr_cnt), dout, exp_mem[wr_cnt]);
            dst_mem[wr_cnt] = dout;
         end
         if (first_wen_k < 0) first_wen_k = cyc - acc;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_k = cyc - acc;
      end
   end

   task automatic clear_mon();
      wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
      first_ren_k = -1; first_wen_k = -1; done_k = -1;
   endtask

   task automatic run_pass(input int dup_a, input int dup_b, input bit start_in_done);
      bit seen = 1'b0;
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      acc = cyc;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) seen = 1'b1;
         else start = ((cyc - acc) == dup_a) || ((cyc - acc) == dup_b);
      end
      start = start_in_done && seen;
      check("pass_done_seen", seen, 1);
      @(negedge clk); #1;
      start = 1'b0;
      check("idle_after_done", busy, 0);
      check("done_pulses", done_cnt, 1);
      check("write_count", wr_cnt, N_WORDS);
      check("read_count", rd_cnt, N_WORDS);
      check("first_ren_lat", first_ren_k, 0);
      check("first_wen_lat", first_wen_k, 1 + SUB_LAT);
      check("done_lat", done_k, N_WORDS + SUB_LAT + 1);
   endtask

   function automatic logic [15:0] dst_pix(input int w, input int lane);
      return dst_mem[w][lane*FP16_W +: FP16_W];
   endfunction

   int wsnap;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      din   = '0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_ctrl", {ren, wen, busy, done}, 0);
         check("idle_addr", {raddr, waddr}, 0);
      end
      check("reset_dout", dout, 0);
      #1;

      // all 1.0
      for (int w = 0; w < N_WORDS; w++) src_mem[w] = {PORT_SIZE{16'h3C00}};
      build_expected();
      run_pass(-1, -1, 1'b0);
      check("ones_col0", dst_mem[0], 256'hBC00);
      check("ones_col1", dst_mem[1], 256'h0);
      check("ones_col2", dst_mem[2], 256'h0);
      check("ones_col3", dst_mem[3], {16'h3C00, 240'h0});
      check("ones_last_row_col0", dst_mem[N_WORDS-4], 256'hBC00);
      check("ones_last_row_col3", dst_mem[N_WORDS-1], {16'h3C00, 240'h0});

      // ramp in row 0, random elsewhere; start during DONE is ignored
      gen_frame(1'b1);
      run_pass(-1, -1, 1'b1);
      check("ramp_p0", dst_pix(0, 0), 16'h0000);
      check("ramp_p1", dst_pix(0, 1), 16'hBC00);
      check("ramp_p15", dst_pix(0, 15), 16'hBC00);
      check("ramp_p16_carry", dst_pix(1, 0), 16'hBC00);
      check("ramp_p48_carry", dst_pix(3, 0), 16'hBC00);
      check("ramp_p62", dst_pix(3, 14), 16'hBC00);
      check("ramp_p63", dst_pix(3, 15), 16'h53C0);
      // back-to-back pass on the same frame
      run_pass(-1, -1, 1'b0);
      check("b2b_p63", dst_pix(3, 15), 16'h53C0);

      // random frame with start pulses while busy
      gen_frame(1'b0);
      run_pass(5, 100, 1'b0);

      // reset in the middle of a pass
      gen_frame(1'b0);
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      acc = cyc;
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_abort_ctrl", {ren, wen, busy, done}, 0);
      check("rst_abort_addr", {raddr, waddr}, 0);
      check("rst_abort_dout", dout, 0);
      wsnap    = wr_cnt;
      done_cnt = 0;
      repeat (30) @(negedge clk);
      check("rst_no_wen", wr_cnt, wsnap);
      check("rst_no_done", done_cnt, 0);
      #1;
      gen_frame(1'b0);
      run_pass(-1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dxt_diff.md
Name: dxt_diff

Overview:
- Computes the adjoint (transpose) of the horizontal forward-difference operator, dxT, for the GAP-TV datapath.
- Reads dx-domain fp16 words from a BRAM and writes dxT(d) words to a second BRAM using the same word/row address layout as the forward dx engine.
- Runs one full frame pass per start pulse.
- Completes the gradient/divergence pair that the TV denoising step requires.

Parameters:
- PORT_SIZE, 16: fp16 lanes per BRAM word.
- COL_WIDTH, 4: words per image row; row width W = PORT_SIZE*COL_WIDTH = 64 pixels.
- ROW_NUM, 48: rows per frame; N = ROW_NUM*COL_WIDTH = 192 words.
- SUB_LAT, 3: fixed pipeline latency of the fp16 subtractor core, in cycles.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame pass when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the last word has been written.
- ren  out  1  read enable of the source BRAM.
- raddr  out  8  read word address = row*COL_WIDTH + col.
- din  in  PORT_SIZE*16  source word, valid 1 cycle after ren.
- wen  out  1  write enable of the destination BRAM.
- waddr  out  8  write word address.
- dout  out  PORT_SIZE*16  result word, valid while wen=1.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Pixel index p = col*PORT_SIZE + lane, lane 0 in din[15:0].
- Transfer function per row:
  - dxt[0] = 0 - d[0]
  - dxt[p] = d[p-1] - d[p] for 0 < p < W-1
  - dxt[W-1] = d[W-2] - 0
- Reset: state IDLE; ren, wen, busy, done = 0; raddr, waddr, carry = 0; dout = 0.
- FSM states:
  - IDLE: on start go to READ; raddr=0, ren=1 in the first READ cycle.
  - READ: ren=1 every cycle; raddr steps with col ascending 0..COL_WIDTH-1, then row+1. After address N-1 is issued, go to DRAIN.
  - DRAIN: ren=0; wait until the write counter reaches N.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ, DRAIN and DONE.
- Read pipeline:
  - rvalid is ren delayed by 1 cycle, with the matching col tag.
  - When rvalid=1, lane L of the subtractor computes minuend - subtrahend.
  - Lane 0 minuend = carry; carry is forced to 0 when col==0.
  - Lane L>0 minuend = din lane L-1.
  - Subtrahend = din lane L, except lane PORT_SIZE-1 at col==COL_WIDTH-1, where it is forced to 0x0000.
  - carry <= din lane PORT_SIZE-1 on every rvalid cycle.
- Write pipeline:
  - wen = rvalid delayed by SUB_LAT; dout = subtractor outputs.
  - waddr starts at 0 and increments after each write; words are written in read order.
- Latency:
  - First wen occurs 1+SUB_LAT cycles after the first ren.
  - Last write occurs in cycle N+SUB_LAT counted from the first ren at cycle 0.
  - done is asserted the following cycle.
- Boundaries and corner cases:
  - start while busy is ignored.
  - start coincident with rst: rst wins.
  - rst mid-pass: aborts immediately to the reset state; all in-flight pipeline valids are cleared, so there are no further wen and no done.
  - Address counters wrap to 0 after N-1.
  - fp16 arithmetic follows the core (round-to-nearest-even); 0-0 and x-x yield +0 (0x0000).
  - A start accepted in the DONE cycle is ignored; it is accepted only in IDLE.

Decomposition:
- Shared package: PORT_SIZE, COL_WIDTH, ROW_NUM, FP16_W=16, and the fp16 zero constant.
- Sub-module dxt_addr_counter: row/col counter with en, ascending col, wrap, last flag. Instantiated twice, once for reads and once for writes.
- Lane subtractors use the existing fp16_subtract core; the valid pipeline is kept internal to dxt_diff.

Test Plan:
- Reset then idle, no start -> ren=wen=busy=done=0 for 20 cycles; raddr=waddr=0.
- Frame of all 1.0 (0x3C00) -> each row:
  - word col0: lane0=0xBC00, other lanes 0x0000.
  - word col3: lane15=0x3C00, other lanes 0x0000.
  - cols 1-2: all 0x0000.
  - 192 writes, waddr 0..191; done 196 cycles after start acceptance with SUB_LAT=3.
- Ramp d[p]=p as fp16 in row 0 -> dxt[0]=0x8000-free 0xBC00·0 check (d[0]=0 gives +0 0x0000), dxt[p]=0xBC00 (-1.0) for p=1..62, dxt[63]=62.0 (0x53C0); lane-16 cross-word carry verified.
- start pulsed again at cycles 5 and 100 while busy -> ignored; exactly 192 writes and one done.
- rst asserted at cycle 50 of a pass -> next cycle ren=wen=busy=0, no done; a new start yields a correct full pass from address 0.
- Back-to-back start issued the cycle after done -> second pass identical, waddr restarts at 0.
